// File: rtl/sa_seq_if.sv
// Activation-in / subarray / result-out signal bundle for the subarray sequencer.
// The slave side is the sequencer; the master side is the environment that surrounds it.
interface sa_seq_if #(
  parameter int N_ROWS  = 256,
  parameter int N_COLS  = 256,
  parameter int BIT_ADC = 4,
  parameter int IN_PREC = 4
);
  logic                        act_valid_i;
  logic                        act_ready_o;
  logic [N_ROWS*IN_PREC-1:0]   act_data_i;
  logic [N_ROWS-1:0]           sa_bit_o;
  logic [N_COLS*BIT_ADC-1:0]   sa_comp_i;
  logic                        sa_done_i;
  logic                        res_valid_o;
  logic                        res_ready_i;
  logic [N_COLS*BIT_ADC-1:0]   res_data_o;
  logic                        busy_o;
  logic                        sync_err_o;
  logic                        err_clr_i;
  logic [15:0]                 ops_count_o;

  modport slave (
    input  act_valid_i, act_data_i, sa_comp_i, sa_done_i, res_ready_i, err_clr_i,
    output act_ready_o, sa_bit_o, res_valid_o, res_data_o, busy_o, sync_err_o, ops_count_o
  );

  modport master (
    output act_valid_i, act_data_i, sa_comp_i, sa_done_i, res_ready_i, err_clr_i,
    input  act_ready_o, sa_bit_o, res_valid_o, res_data_o, busy_o, sync_err_o, ops_count_o
  );
endinterface

// File: rtl/sa_seq_ctrl.sv
// Subarray sequencer: latches an activation vector, feeds it LSB-first one bit per row per
// cycle (optionally phase-aligned to the subarray done pulse), captures the ADC outputs, holds them.
module sa_seq_ctrl #(
  parameter int N_ROWS       = 256,
  parameter int N_COLS       = 256,
  parameter int BIT_ADC      = 4,
  parameter int IN_PREC      = 4,
  parameter int SYNC_EN      = 1,
  parameter int SYNC_TIMEOUT = 8
) (
  input  logic     clk,
  input  logic     nrst,
  sa_seq_if.slave  bus
);

  localparam int RW = N_COLS * BIT_ADC;
  localparam int KW = (IN_PREC > 1) ? $clog2(IN_PREC) : 1;
  localparam int SW = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT) : 1;

  localparam logic [KW-1:0] LAST_K  = KW'(IN_PREC - 1);
  localparam logic [SW-1:0] LAST_SC = SW'(SYNC_TIMEOUT - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SYNC = 3'd1;
  localparam logic [2:0] S_FEED = 3'd2;
  localparam logic [2:0] S_CAPT = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;

  logic [2:0]                      state_q, state_d;
  logic [KW-1:0]                   k_q, k_d;
  logic [SW-1:0]                   sc_q, sc_d;
  logic [N_ROWS-1:0][IN_PREC-1:0]  vec_q, vec_d;
  logic [RW-1:0]                   res_q, res_d;
  logic                            err_q, err_d;
  logic [15:0]                     ops_q, ops_d;
  logic                            act_ready_q;
  logic                            set_err;
  logic [N_ROWS-1:0]               sa_bit;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    sc_d    = sc_q;
    vec_d   = vec_q;
    res_d   = res_q;
    ops_d   = ops_q;
    set_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.act_valid_i && act_ready_q) begin
          vec_d   = bus.act_data_i;
          k_d     = '0;
          sc_d    = '0;
          state_d = (SYNC_EN != 0) ? S_SYNC : S_FEED;
        end
      end
      S_SYNC: begin
        sc_d = sc_q + 1'b1;
        if (bus.sa_done_i) begin
          state_d = S_FEED;
        end else if (sc_q == LAST_SC) begin
          // Give up waiting for the done pulse; the operation still completes.
          set_err = 1'b1;
          state_d = S_FEED;
        end
      end
      S_FEED: begin
        k_d = k_q + 1'b1;
        if (k_q == LAST_K) begin
          state_d = S_CAPT;
          if ((SYNC_EN != 0) && !bus.sa_done_i) set_err = 1'b1;
        end
      end
      S_CAPT: begin
        res_d   = bus.sa_comp_i;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (bus.res_ready_i) begin
          ops_d   = ops_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A new error in the same cycle as a clear request survives the clear.
    err_d = set_err | (err_q & ~bus.err_clr_i);
  end

  // ---- register stage: FSM, vector, result, status ----
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      sc_q        <= '0;
      vec_q       <= '0;
      res_q       <= '0;
      err_q       <= 1'b0;
      ops_q       <= '0;
      act_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      sc_q        <= sc_d;
      vec_q       <= vec_d;
      res_q       <= res_d;
      err_q       <= err_d;
      ops_q       <= ops_d;
      act_ready_q <= (state_d == S_IDLE);
    end
  end

  for (genvar r = 0; r < N_ROWS; r++) begin : g_row
    assign sa_bit[r] = (state_q == S_FEED) & vec_q[r][k_q];
  end

  assign bus.act_ready_o = act_ready_q;
  assign bus.sa_bit_o    = sa_bit;
  assign bus.res_valid_o = (state_q == S_HOLD);
  assign bus.res_data_o  = res_q;
  assign bus.busy_o      = (state_q != S_IDLE);
  assign bus.sync_err_o  = err_q;
  assign bus.ops_count_o = ops_q;

endmodule

// File: tb/tb_sa_seq_ctrl.sv
// Bench for sa_seq_ctrl: one instance without and one with done-pulse alignment, each driving a
// shift-register subarray surrogate whose column c reports (row c activation + 1).
module tb_sa_seq_ctrl;
  localparam int N_ROWS = 8, N_COLS = 4, BIT_ADC = 4, IN_PREC = 4, SYNC_TIMEOUT = 8;
  localparam int DW = N_ROWS * IN_PREC;
  localparam int RW = N_COLS * BIT_ADC;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  sa_seq_if #(.N_ROWS(N_ROWS), .N_COLS(N_COLS), .BIT_ADC(BIT_ADC), .IN_PREC(IN_PREC)) if0 ();
  sa_seq_if #(.N_ROWS(N_ROWS), .N_COLS(N_COLS), .BIT_ADC(BIT_ADC), .IN_PREC(IN_PREC)) if1 ();

  sa_seq_ctrl #(.N_ROWS(N_ROWS), .N_COLS(N_COLS), .BIT_ADC(BIT_ADC), .IN_PREC(IN_PREC),
                .SYNC_EN(0), .SYNC_TIMEOUT(SYNC_TIMEOUT)) dut0 (.clk(clk), .nrst(nrst), .bus(if0));
  sa_seq_ctrl #(.N_ROWS(N_ROWS), .N_COLS(N_COLS), .BIT_ADC(BIT_ADC), .IN_PREC(IN_PREC),
                .SYNC_EN(1), .SYNC_TIMEOUT(SYNC_TIMEOUT)) dut1 (.clk(clk), .nrst(nrst), .bus(if1));

  logic          sel = 1'b0, act_valid = 1'b0, res_ready = 1'b0, err_clr = 1'b0, done_en = 1'b0;
  logic [DW-1:0] act_data = '0;
  int            dcnt = 0;

  assign if0.act_valid_i = act_valid & ~sel;
  assign if1.act_valid_i = act_valid & sel;
  assign if0.act_data_i  = act_data;
  assign if1.act_data_i  = act_data;
  assign if0.res_ready_i = res_ready & ~sel;
  assign if1.res_ready_i = res_ready & sel;
  assign if0.err_clr_i   = err_clr & ~sel;
  assign if1.err_clr_i   = err_clr & sel;
  assign if0.sa_done_i   = 1'b0;
  assign if1.sa_done_i   = done_en & (dcnt == 3);

  // Free-running done pulse with period 4
  always @(posedge clk) dcnt <= (dcnt + 1) % 4;

  logic [IN_PREC-1:0] sh0 [N_COLS];
  logic [IN_PREC-1:0] sh1 [N_COLS];
  always @(posedge clk)
    for (int c = 0; c < N_COLS; c++) begin
      sh0[c] <= {if0.sa_bit_o[c], sh0[c][IN_PREC-1:1]};
      sh1[c] <= {if1.sa_bit_o[c], sh1[c][IN_PREC-1:1]};
    end
  always_comb begin
    if0.sa_comp_i = '0;
    if1.sa_comp_i = '0;
    for (int c = 0; c < N_COLS; c++) begin
      if0.sa_comp_i[c*BIT_ADC +: BIT_ADC] = sh0[c] + 4'd1;
      if1.sa_comp_i[c*BIT_ADC +: BIT_ADC] = sh1[c] + 4'd1;
    end
  end

  wire              m_act_ready = sel ? if1.act_ready_o : if0.act_ready_o;
  wire              m_res_valid = sel ? if1.res_valid_o : if0.res_valid_o;
  wire              m_busy      = sel ? if1.busy_o      : if0.busy_o;
  wire              m_sync_err  = sel ? if1.sync_err_o  : if0.sync_err_o;
  wire [15:0]       m_ops       = sel ? if1.ops_count_o : if0.ops_count_o;
  wire [RW-1:0]     m_res       = sel ? if1.res_data_o  : if0.res_data_o;
  wire [N_ROWS-1:0] m_sa_bit    = sel ? if1.sa_bit_o    : if0.sa_bit_o;

  int               checks = 0, errors = 0;
  int               lat, ph, bad;
  int               ops_m [2];
  logic [N_ROWS-1:0] flog [64];
  logic             elog [64];

  // ---- reference model ----
  function automatic logic [N_ROWS-1:0] slice(input logic [DW-1:0] d, input int k);
    logic [N_ROWS-1:0] s;
    for (int r = 0; r < N_ROWS; r++) s[r] = d[r*IN_PREC + k];
    return s;
  endfunction

  function automatic logic [N_ROWS-1:0] exp_feed(input logic [DW-1:0] d, input int n, input int j);
    if (j >= n && j < n + IN_PREC) return slice(d, j - n);
    return '0;
  endfunction

  function automatic logic [RW-1:0] exp_res(input logic [DW-1:0] d);
    logic [RW-1:0] e;
    for (int c = 0; c < N_COLS; c++) e[c*BIT_ADC +: BIT_ADC] = d[c*IN_PREC +: IN_PREC] + 4'd1;
    return e;
  endfunction

  function automatic int exp_nsync(input int p);
    for (int j = 1; j <= SYNC_TIMEOUT; j++) if ((p + j) % 4 == 3) return j;
    return SYNC_TIMEOUT;
  endfunction

  // ---- drivers ----
  task automatic do_op(input logic [DW-1:0] d, input int want_ph, input int clr_at);
    int n = 0;
    while (!(m_act_ready && (want_ph < 0 || dcnt == want_ph)) && n < 50) begin
      @(negedge clk); n++;
    end
    checks++;
    if (m_act_ready !== 1'b1) begin
      errors++; $display("FAIL accept_wait: act_ready=%0b required 1", m_act_ready);
    end
    ph = dcnt; act_valid = 1'b1; act_data = d;
    @(negedge clk);
    act_valid = 1'b0; act_data = DW'($urandom);
    lat = 1;
    while (!m_res_valid && lat < 40) begin
      flog[lat-1] = m_sa_bit;
      err_clr = (lat == clr_at);
      @(negedge clk);
      elog[lat-1] = m_sync_err;
      lat++;
    end
    err_clr = 1'b0;
  endtask

  task automatic accept();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    ops_m[sel] = (ops_m[sel] + 1) % 65536;
  endtask

  // ---- tests ----
  task automatic test_reset();
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({if0.act_ready_o, if0.res_valid_o, if0.busy_o, if0.sync_err_o, if0.ops_count_o,
         if0.res_data_o, if0.sa_bit_o} !== '0) begin
      errors++; $display("FAIL reset_dut0: busy=%0b ready=%0b ops=%h required all 0",
                         if0.busy_o, if0.act_ready_o, if0.ops_count_o);
    end
    checks++;
    if ({if1.act_ready_o, if1.res_valid_o, if1.busy_o, if1.sync_err_o, if1.ops_count_o,
         if1.res_data_o, if1.sa_bit_o} !== '0) begin
      errors++; $display("FAIL reset_dut1: busy=%0b ready=%0b ops=%h required all 0",
                         if1.busy_o, if1.act_ready_o, if1.ops_count_o);
    end
    nrst = 1'b1;
    @(negedge clk);
    checks++;
    if ({if0.act_ready_o, if1.act_ready_o} !== 2'b11) begin
      errors++; $display("FAIL ready_after_reset: %b required 11", {if0.act_ready_o, if1.act_ready_o});
    end
    ops_m[0] = 0; ops_m[1] = 0;
  endtask

  task automatic test_basic();
    logic [DW-1:0] d;
    logic [3:0]    r0;
    sel = 1'b0;
    d = DW'($urandom);
    d[3:0] = 4'b1011; d[7:4] = 4'b0110;
    do_op(d, -1, -1);
    checks++;
    if (lat !== IN_PREC + 2) begin errors++; $display("FAIL basic_latency: %0d required %0d", lat, IN_PREC + 2); end
    r0 = {flog[3][0], flog[2][0], flog[1][0], flog[0][0]};
    checks++;
    if (r0 !== 4'b1011) begin errors++; $display("FAIL basic_row0_bits: %b required 1011", r0); end
    bad = 0;
    for (int j = 0; j < lat - 1; j++) if (flog[j] !== exp_feed(d, 0, j)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL basic_feed: %0d cycles wrong, required 0", bad); end
    checks++;
    if (m_res[3:0] !== 4'd12) begin errors++; $display("FAIL basic_col0: %0d required 12", m_res[3:0]); end
    checks++;
    if (m_res !== exp_res(d)) begin errors++; $display("FAIL basic_res: %h required %h", m_res, exp_res(d)); end
    checks++;
    if ({m_busy, m_act_ready} !== 2'b10) begin errors++; $display("FAIL basic_hold_flags: busy,ready=%b required 10", {m_busy, m_act_ready}); end
    accept();
    checks++;
    if ({m_ops, m_res_valid, m_act_ready, m_busy} !== {16'(ops_m[0]), 3'b010}) begin
      errors++; $display("FAIL basic_done: ops=%0d valid=%0b ready=%0b required ops=%0d valid=0 ready=1",
                         m_ops, m_res_valid, m_act_ready, ops_m[0]);
    end
  endtask

  task automatic test_sync();
    logic [DW-1:0] d;
    int n;
    sel = 1'b1; done_en = 1'b1;
    d = DW'($urandom);
    do_op(d, 1, -1);
    n = exp_nsync(ph);
    checks++;
    if (lat !== n + IN_PREC + 2 || n != 2) begin errors++; $display("FAIL sync_latency: %0d required %0d", lat, 2 + IN_PREC + 2); end
    bad = 0;
    for (int j = 0; j < lat - 1; j++) if (flog[j] !== exp_feed(d, n, j)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL sync_feed: %0d cycles wrong, required 0", bad); end
    checks++;
    if (m_sync_err !== 1'b0) begin errors++; $display("FAIL sync_err_aligned: %0b required 0", m_sync_err); end
    checks++;
    if (m_res !== exp_res(d)) begin errors++; $display("FAIL sync_res: %h required %h", m_res, exp_res(d)); end
    accept();
  endtask

  task automatic test_timeout();
    logic [DW-1:0] d;
    sel = 1'b1; done_en = 1'b0;
    d = DW'($urandom);
    do_op(d, -1, SYNC_TIMEOUT);
    checks++;
    if (lat !== SYNC_TIMEOUT + IN_PREC + 2) begin
      errors++; $display("FAIL timeout_latency: %0d required %0d", lat, SYNC_TIMEOUT + IN_PREC + 2);
    end
    bad = 0;
    for (int j = 0; j < lat - 1; j++) if (flog[j] !== exp_feed(d, SYNC_TIMEOUT, j)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL timeout_feed: %0d cycles wrong, required 0", bad); end
    checks++;
    if (elog[SYNC_TIMEOUT-2] !== 1'b0) begin errors++; $display("FAIL timeout_early_err: %0b required 0", elog[SYNC_TIMEOUT-2]); end
    checks++;
    if (elog[SYNC_TIMEOUT-1] !== 1'b1) begin errors++; $display("FAIL set_wins_over_clr: %0b required 1", elog[SYNC_TIMEOUT-1]); end
    checks++;
    if (m_res !== exp_res(d)) begin errors++; $display("FAIL timeout_res: %h required %h", m_res, exp_res(d)); end
    accept();
    checks++;
    if (m_sync_err !== 1'b1) begin errors++; $display("FAIL err_sticky: %0b required 1", m_sync_err); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if (m_sync_err !== 1'b0) begin errors++; $display("FAIL err_clear: %0b required 0", m_sync_err); end
    done_en = 1'b1;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d;
    sel = 1'b0;
    d = DW'($urandom);
    do_op(d, -1, -1);
    res_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({m_res_valid, m_act_ready} !== 2'b10 || m_res !== exp_res(d)) begin
        errors++; $display("FAIL backpressure_%0d: valid=%0b ready=%0b res=%h required 1 0 %h",
                           i, m_res_valid, m_act_ready, m_res, exp_res(d));
      end
      @(negedge clk);
    end
    accept();
    checks++;
    if ({m_ops, m_act_ready, m_res_valid} !== {16'(ops_m[0]), 2'b10}) begin
      errors++; $display("FAIL backpressure_release: ops=%0d ready=%0b valid=%0b required %0d 1 0",
                         m_ops, m_act_ready, m_res_valid, ops_m[0]);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    int n;
    logic e;
    done_en = 1'b1;
    for (int it = 0; it < 24; it++) begin
      sel = 1'($urandom_range(0, 1));
      d = DW'($urandom);
      do_op(d, -1, -1);
      n = sel ? exp_nsync(ph) : 0;
      e = sel ? ((ph + n + IN_PREC) % 4 != 3) : 1'b0;
      checks++;
      if (lat !== n + IN_PREC + 2) begin errors++; $display("FAIL rand_latency_%0d: %0d required %0d", it, lat, n + IN_PREC + 2); end
      bad = 0;
      for (int j = 0; j < lat - 1; j++) if (flog[j] !== exp_feed(d, n, j)) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL rand_feed_%0d: %0d cycles wrong, required 0", it, bad); end
      checks++;
      if (m_res !== exp_res(d) || m_sync_err !== e) begin
        errors++; $display("FAIL rand_res_%0d: res=%h err=%0b required %h %0b", it, m_res, m_sync_err, exp_res(d), e);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      accept();
      checks++;
      if (m_ops !== 16'(ops_m[sel])) begin errors++; $display("FAIL rand_ops_%0d: %0d required %0d", it, m_ops, ops_m[sel]); end
    end
  endtask

  task automatic test_wrap();
    sel = 1'b0;
    force dut0.ops_q = 16'hFFFF;
    repeat (2) @(negedge clk);
    release dut0.ops_q;
    @(negedge clk);
    ops_m[0] = 65535;
    checks++;
    if (m_ops !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: %h required ffff", m_ops); end
    do_op(DW'($urandom), -1, -1);
    accept();
    checks++;
    if (m_ops !== 16'h0000 || m_ops !== 16'(ops_m[0])) begin errors++; $display("FAIL wrap: %h required 0000", m_ops); end
  endtask

  task automatic test_async_reset();
    logic [DW-1:0] d, d2;
    int n = 0;
    sel = 1'b0;
    d = DW'($urandom);
    while (!m_act_ready && n < 20) begin @(negedge clk); n++; end
    act_valid = 1'b1; act_data = d;
    @(negedge clk);
    act_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (m_sa_bit !== slice(d, 2)) begin errors++; $display("FAIL feed_k2: %b required %b", m_sa_bit, slice(d, 2)); end
    #2 nrst = 1'b0;
    #1;
    checks++;
    if ({if0.act_ready_o, if0.res_valid_o, if0.busy_o, if0.sync_err_o, if0.ops_count_o,
         if0.res_data_o, if0.sa_bit_o} !== '0) begin
      errors++; $display("FAIL async_reset: busy=%0b bits=%b ops=%h required all 0",
                         if0.busy_o, if0.sa_bit_o, if0.ops_count_o);
    end
    @(negedge clk);
    nrst = 1'b1;
    ops_m[0] = 0; ops_m[1] = 0;
    d2 = DW'($urandom);
    do_op(d2, -1, -1);
    checks++;
    if (lat !== IN_PREC + 2 || m_res !== exp_res(d2)) begin
      errors++; $display("FAIL post_reset_op: lat=%0d res=%h required %0d %h", lat, m_res, IN_PREC + 2, exp_res(d2));
    end
    bad = 0;
    for (int j = 0; j < lat - 1; j++) if (flog[j] !== exp_feed(d2, 0, j)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL post_reset_feed: %0d cycles wrong, required 0", bad); end
    accept();
    checks++;
    if (m_ops !== 16'd1) begin errors++; $display("FAIL post_reset_ops: %0d required 1", m_ops); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sync();
    test_timeout();
    test_backpressure();
    test_random();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
